// File: rtl/aes_encipher_ctrl.sv
// aes_encipher_ctrl: round sequencer for the AES encipher datapath.
// Steps INIT -> (4x SBOX word passes + MAIN) per round -> FINAL, and drives
// the round-key index, update type, shared S-box word select and block write
// enable. Every output is a register loaded from the decode of the next state,
// so next/keylen never reach an output combinationally.
module aes_encipher_ctrl #(
  parameter int AES128_ROUNDS = 10,
  parameter int AES256_ROUNDS = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       next,
  input  logic       keylen,
  output logic [3:0] round,
  output logic [2:0] update_type,
  output logic [1:0] sword_sel,
  output logic       block_we,
  output logic       ready
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_SBOX  = 3'd2;
  localparam logic [2:0] ST_MAIN  = 3'd3;
  localparam logic [2:0] ST_FINAL = 3'd4;

  localparam logic [2:0] UPD_NONE  = 3'd0;
  localparam logic [2:0] UPD_INIT  = 3'd1;
  localparam logic [2:0] UPD_SBOX  = 3'd2;
  localparam logic [2:0] UPD_MAIN  = 3'd3;
  localparam logic [2:0] UPD_FINAL = 3'd4;

  localparam logic [3:0] ROUNDS_128 = 4'(AES128_ROUNDS);
  localparam logic [3:0] ROUNDS_256 = 4'(AES256_ROUNDS);

  logic [2:0] state_q, state_d;
  logic [3:0] round_ctr_q, round_ctr_d;
  logic [1:0] sword_ctr_q, sword_ctr_d;
  logic       keylen_q, keylen_d;
  logic [3:0] num_rounds_s;

  logic [3:0] round_q, round_d;
  logic [2:0] update_type_q, update_type_d;
  logic [1:0] sword_sel_q, sword_sel_d;
  logic       block_we_q, block_we_d;
  logic       ready_q, ready_d;

  assign num_rounds_s = keylen_q ? ROUNDS_256 : ROUNDS_128;

  // Next-state and counter update for the round sequencer.
  always_comb begin
    state_d     = state_q;
    round_ctr_d = round_ctr_q;
    sword_ctr_d = sword_ctr_q;
    keylen_d    = keylen_q;
    case (state_q)
      ST_IDLE: begin
        if (next) begin
          state_d     = ST_INIT;
          keylen_d    = keylen;
          round_ctr_d = 4'd0;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_INIT: begin
        state_d     = ST_SBOX;
        round_ctr_d = 4'd1;
        sword_ctr_d = 2'd0;
      end
      ST_SBOX: begin
        if (sword_ctr_q == 2'd3) begin
          sword_ctr_d = 2'd0;
          if (round_ctr_q < num_rounds_s) begin
            state_d = ST_MAIN;
          end else begin
            state_d = ST_FINAL;
          end
        end else begin
          sword_ctr_d = sword_ctr_q + 2'd1;
        end
      end
      ST_MAIN: begin
        round_ctr_d = round_ctr_q + 4'd1;
        state_d     = ST_SBOX;
      end
      ST_FINAL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        round_ctr_d = 4'd0;
        sword_ctr_d = 2'd0;
      end
    endcase
  end

  // Output decode of the upcoming state, registered below alongside it.
  always_comb begin
    round_d       = round_ctr_d;
    update_type_d = UPD_NONE;
    sword_sel_d   = 2'd0;
    block_we_d    = 1'b1;
    ready_d       = 1'b0;
    case (state_d)
      ST_IDLE: begin
        round_d    = 4'd0;
        block_we_d = 1'b0;
        ready_d    = 1'b1;
      end
      ST_INIT:  update_type_d = UPD_INIT;
      ST_SBOX: begin
        update_type_d = UPD_SBOX;
        sword_sel_d   = sword_ctr_d;
      end
      ST_MAIN:  update_type_d = UPD_MAIN;
      ST_FINAL: update_type_d = UPD_FINAL;
      default: begin
        round_d    = 4'd0;
        block_we_d = 1'b0;
        ready_d    = 1'b1;
      end
    endcase
  end

  // State, counters, latched key length and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      round_ctr_q   <= 4'd0;
      sword_ctr_q   <= 2'd0;
      keylen_q      <= 1'b0;
      round_q       <= 4'd0;
      update_type_q <= UPD_NONE;
      sword_sel_q   <= 2'd0;
      block_we_q    <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      round_ctr_q   <= round_ctr_d;
      sword_ctr_q   <= sword_ctr_d;
      keylen_q      <= keylen_d;
      round_q       <= round_d;
      update_type_q <= update_type_d;
      sword_sel_q   <= sword_sel_d;
      block_we_q    <= block_we_d;
      ready_q       <= ready_d;
    end
  end

  assign round       = round_q;
  assign update_type = update_type_q;
  assign sword_sel   = sword_sel_q;
  assign block_we    = block_we_q;
  assign ready       = ready_q;

endmodule
